// File: rtl/u_32b_div_seq.sv
// u_32b_div_seq: sequential unsigned restoring divider that produces one quotient bit per clock.
// Optional macro U32B_DIV_ZERO_FAST_EN: a zero divisor completes one cycle after accept and raises div_by_zero.

module u_32b_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] dvd_q, dvd_n;    // dividend shifts out MSB-first, quotient bits shift in at LSB
    logic [WIDTH-1:0] dvs_q, dvs_n;
    logic [WIDTH-1:0] part_q, part_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             busy_n, done_n, dbz_n;
    logic [WIDTH-1:0] quo_n, rem_n;
`ifdef U32B_DIV_ZERO_FAST_EN
    logic             zero_q, zero_n;
`endif

    // The working remainder is WIDTH+1 bits wide. Its top bit is always zero once a step
    // finishes, so only the lower WIDTH bits are stored between cycles.
    logic [WIDTH:0]   shifted, diff;
    logic             q_bit;
    logic [WIDTH-1:0] step_part, step_dvd;

    always_comb begin
        shifted   = {part_q, dvd_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvs_q};
        q_bit     = ~diff[WIDTH];
        step_part = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        step_dvd  = {dvd_q[WIDTH-2:0], q_bit};
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_n = state;
        dvd_n   = dvd_q;
        dvs_n   = dvs_q;
        part_n  = part_q;
        cnt_n   = cnt_q;
        busy_n  = busy;
        done_n  = 1'b0;
        quo_n   = quotient;
        rem_n   = remainder;
        dbz_n   = div_by_zero;
`ifdef U32B_DIV_ZERO_FAST_EN
        zero_n  = zero_q;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    busy_n  = 1'b1;
                    dvd_n   = dividend;
                    dvs_n   = divisor;
                    part_n  = '0;
                    cnt_n   = '0;
`ifdef U32B_DIV_ZERO_FAST_EN
                    zero_n  = (divisor == '0);
`endif
                end
            end

            RUN: begin
`ifdef U32B_DIV_ZERO_FAST_EN
                if (zero_q) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    quo_n   = '1;
                    rem_n   = dvd_q;
                    dbz_n   = 1'b1;
                    zero_n  = 1'b0;
                end else
`endif
                begin
                    dvd_n  = step_dvd;
                    part_n = step_part;
                    cnt_n  = cnt_q + 1'b1;
                    // The final step retires straight into the result registers.
                    if (cnt_q == '1) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        quo_n   = step_dvd;
                        rem_n   = step_part;
                        dbz_n   = 1'b0;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath is reset along with the control state, so the results read as zero after reset.
            state       <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            part_q      <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef U32B_DIV_ZERO_FAST_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
            state       <= state_n;
            dvd_q       <= dvd_n;
            dvs_q       <= dvs_n;
            part_q      <= part_n;
            cnt_q       <= cnt_n;
            busy        <= busy_n;
            done        <= done_n;
            quotient    <= quo_n;
            remainder   <= rem_n;
            div_by_zero <= dbz_n;
`ifdef U32B_DIV_ZERO_FAST_EN
            zero_q      <= zero_n;
`endif
        end
    end

endmodule
